// File: rtl/sram_mask_2p.sv
// ---------------------------------------------------------------------------
// sram_mask_2p
//
// Two-port (one write, one read) SRAM with a per-bit write mask, a
// self-clearing initialisation sequence after reset and an optional output
// register stage.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH words
//   OUT_REG    : 0 = read latency 1, 1 = extra output register (latency 2)
//   WR_BYPASS  : 1 = same-cycle same-address read returns the merged new
//                word, 0 = returns the pre-write word
//
// Ports
//   CLK   in   1           clock, all state updates on rising edge
//   RST   in   1           asynchronous reset, active-high
//   WE    in   1           write request
//   WA    in   ADDR_WIDTH  write address
//   WD    in   DATA_WIDTH  write data
//   WEN   in   DATA_WIDTH  per-bit write mask, 1 = write that bit
//   RE    in   1           read request
//   RA    in   ADDR_WIDTH  read address
//   Q     out  DATA_WIDTH  read data, holds its value while RVLD = 0
//   RVLD  out  1           Q carries the result of a read this cycle
//   BUSY  out  1           initialisation running, WE/RE ignored
// ---------------------------------------------------------------------------
module sram_mask_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int WR_BYPASS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] RA,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  RVLD,
  output logic                  BUSY
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;
  logic                  busy_reg;
  logic                  rd_vld_reg;   // stage-1 valid (result in rd_word)

  // -------------------------------------------------------------------------
  // Request qualification and memory write-port muxing
  // -------------------------------------------------------------------------
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  byp_hit;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_bit_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_word;

  // Requests only count once the clear sequence has finished.
  assign wr_fire = (state_reg == ST_IDLE) && WE;
  assign rd_fire = (state_reg == ST_IDLE) && RE;

  // A read colliding with a write to the same address picks up the new
  // bits (where the mask is set) instead of the array contents.
  assign byp_hit = (WR_BYPASS != 0) && wr_fire && (WA == RA);

  // The single write port is shared between the clear sequence and user
  // writes; during INIT the whole word at the counter is zeroed.
  always_comb begin
    mem_addr   = WA;
    mem_bit_we = wr_fire ? WEN : '0;
    mem_wdata  = WD;
    if (state_reg == ST_INIT) begin
      mem_addr   = clr_cnt_reg;
      mem_bit_we = '1;
      mem_wdata  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one single-bit column per data bit so that every bit has its
  // own write enable. Each column has a registered read that only advances
  // on an accepted read, which gives the "Q holds while RVLD = 0" behaviour
  // for free.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_col
      logic mem_col [DEPTH];
      logic rd_bit_reg;

      always_ff @(posedge CLK) begin
        if (mem_bit_we[gi]) begin
          mem_col[mem_addr] <= mem_wdata[gi];
        end
      end

      // Non-blocking read of mem_col returns the pre-write value on a
      // collision; the bypass term substitutes the new bit when enabled.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rd_bit_reg <= 1'b0;
        end else if (rd_fire) begin
          if (byp_hit && WEN[gi]) begin
            rd_bit_reg <= WD[gi];
          end else begin
            rd_bit_reg <= mem_col[RA];
          end
        end
      end

      assign rd_word[gi] = rd_bit_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM: INIT walks the clear counter over every address once,
  // then IDLE serves requests. Reset returns here and discards any read
  // still in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_INIT;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
      rd_vld_reg  <= 1'b0;
    end else begin
      rd_vld_reg <= rd_fire;
      case (state_reg)
        ST_INIT: begin
          clr_cnt_reg <= clr_cnt_reg + ADDR_ONE;
          // Last address cleared on this edge: INIT lasted DEPTH cycles.
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_IDLE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= ST_INIT;
          clr_cnt_reg <= '0;
          busy_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY = busy_reg;

  // -------------------------------------------------------------------------
  // Optional output stage: forwards stage-1 data and valid one cycle later
  // with no bubbles; data only moves when stage 1 holds a real result.
  // -------------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_out_reg;
      logic                  vld_out_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q_out_reg   <= '0;
          vld_out_reg <= 1'b0;
        end else begin
          vld_out_reg <= rd_vld_reg;
          if (rd_vld_reg) begin
            q_out_reg <= rd_word;
          end
        end
      end

      assign Q    = q_out_reg;
      assign RVLD = vld_out_reg;
    end else begin : g_no_out_reg
      assign Q    = rd_word;
      assign RVLD = rd_vld_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sram_mask_2p.sv
// ---------------------------------------------------------------------------
// tb_sram_mask_2p
//
// Two instances share one stimulus stream:
//   dut_a : OUT_REG=0, WR_BYPASS=1 (latency 1, new data on collision)
//   dut_b : OUT_REG=1, WR_BYPASS=0 (latency 2, old data on collision)
// A word-level reference model (memory array, init edge count, and the
// list of reads accepted per edge) produces the expected outputs.
// ---------------------------------------------------------------------------
module tb_sram_mask_2p;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] wen;
  logic          re;
  logic [AW-1:0] ra;
  logic [DW-1:0] q_a, q_b;
  logic          rvld_a, rvld_b, busy_a, busy_b;

  sram_mask_2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .WR_BYPASS(1)) dut_a (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .WEN(wen),
    .RE(re), .RA(ra), .Q(q_a), .RVLD(rvld_a), .BUSY(busy_a)
  );

  sram_mask_2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .WR_BYPASS(0)) dut_b (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .WEN(wen),
    .RE(re), .RA(ra), .Q(q_b), .RVLD(rvld_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_init;        // edges seen since reset release (capped)
  logic          prev_v;        // read accepted one edge ago
  logic [DW-1:0] prev_old;      // its pre-write data
  logic [DW-1:0] exp_a_q, exp_b_q;
  logic          exp_a_vld, exp_b_vld, exp_busy;

  int tests;
  int fails;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_init    = 0;
    prev_v    = 1'b0;
    prev_old  = '0;
    exp_a_q   = '0;
    exp_b_q   = '0;
    exp_a_vld = 1'b0;
    exp_b_vld = 1'b0;
    exp_busy  = 1'b1;
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic cycle(input logic we_i, input logic [AW-1:0] wa_i,
                       input logic [DW-1:0] wd_i, input logic [DW-1:0] wen_i,
                       input logic re_i, input logic [AW-1:0] ra_i);
    logic          now_v;
    logic [DW-1:0] now_old, now_new;
    we  = we_i;  wa = wa_i; wd = wd_i; wen = wen_i;
    re  = re_i;  ra = ra_i;
    @(posedge clk);
    now_v   = 1'b0;
    now_old = '0;
    now_new = '0;
    if (rst) begin
      // held in reset: nothing happens
    end else if (m_init < DEPTH) begin
      m_init++;
    end else begin
      now_old = m_mem[ra_i];
      if (we_i) m_mem[wa_i] = (m_mem[wa_i] & ~wen_i) | (wd_i & wen_i);
      if (re_i) begin
        now_v   = 1'b1;
        now_new = m_mem[ra_i];
      end
    end
    exp_a_vld = now_v;
    if (now_v) exp_a_q = now_new;
    exp_b_vld = prev_v;
    if (prev_v) exp_b_q = prev_old;
    prev_v   = now_v;
    prev_old = now_old;
    exp_busy = (m_init < DEPTH);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  // Run until both instances leave INIT (bounded), with random requests.
  task automatic run_init(output int busy_a_n, output int busy_b_n, output int bad_n);
    busy_a_n = 0;
    busy_b_n = 0;
    bad_n    = 0;
    for (int i = 0; i < 3 * DEPTH && (busy_a === 1'b1 || busy_b === 1'b1); i++) begin
      if (busy_a === 1'b1) busy_a_n++;
      if (busy_b === 1'b1) busy_b_n++;
      if (rvld_a !== 1'b0 || rvld_b !== 1'b0) bad_n++;
      cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom),
            1'b1, AW'($urandom));
    end
  endtask

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    apply_reset();
    tests++;
    if (q_a !== '0 || rvld_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_a: q=%h rvld=%b busy=%b, want q=0 rvld=0 busy=1", q_a, rvld_a, busy_a);
    end
    tests++;
    if (q_b !== '0 || rvld_b !== 1'b0 || busy_b !== 1'b1) begin
      fails++;
      $display("FAIL reset_b: q=%h rvld=%b busy=%b, want q=0 rvld=0 busy=1", q_b, rvld_b, busy_b);
    end
    cycle(1'b1, 10'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 10'd1);
    cycle(1'b1, 10'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 10'd2);
    tests++;
    if (rvld_a !== 1'b0 || rvld_b !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: rvld_a=%b rvld_b=%b busy=%b, want 0 0 1", rvld_a, rvld_b, busy_a);
    end
    rst = 1'b0;
    $display("[TB] reset asserted and held");
  endtask

  task automatic test_init();
    int na, nb, bad;
    run_init(na, nb, bad);
    tests++;
    if (na != DEPTH) begin
      fails++;
      $display("FAIL init_busy_a: got %0d cycles, want %0d", na, DEPTH);
    end
    tests++;
    if (nb != DEPTH) begin
      fails++;
      $display("FAIL init_busy_b: got %0d cycles, want %0d", nb, DEPTH);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL init_rvld: got %0d cycles with RVLD, want 0", bad);
    end
    $display("[TB] init busy cycles a=%0d b=%0d", na, nb);
  endtask

  task automatic test_masked_write();
    cycle(1'b1, 10'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, '0);
    cycle(1'b1, 10'd5, 32'h0000_0000, 32'h0000_FFFF, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd5);
    tests++;
    if (rvld_a !== 1'b1 || q_a !== 32'hDEAD_0000 || rvld_b !== 1'b0) begin
      fails++;
      $display("FAIL mask_lat1: q_a=%h rvld_a=%b rvld_b=%b, want dead0000 1 0", q_a, rvld_a, rvld_b);
    end
    idle();
    tests++;
    if (rvld_a !== 1'b0 || q_a !== 32'hDEAD_0000) begin
      fails++;
      $display("FAIL mask_hold_a: q=%h rvld=%b, want dead0000 0", q_a, rvld_a);
    end
    tests++;
    if (rvld_b !== 1'b1 || q_b !== 32'hDEAD_0000) begin
      fails++;
      $display("FAIL mask_lat2: q=%h rvld=%b, want dead0000 1", q_b, rvld_b);
    end
    $display("[TB] masked write addr 5 read q_a=%h q_b=%h", q_a, q_b);
  endtask

  task automatic test_collision();
    cycle(1'b1, 10'd7, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, '0);
    cycle(1'b1, 10'd7, 32'h2222_2222, 32'hFF00_0000, 1'b1, 10'd7);
    tests++;
    if (rvld_a !== 1'b1 || q_a !== 32'h2211_1111) begin
      fails++;
      $display("FAIL coll_bypass: q=%h rvld=%b, want 22111111 1", q_a, rvld_a);
    end
    idle();
    tests++;
    if (rvld_b !== 1'b1 || q_b !== 32'h1111_1111) begin
      fails++;
      $display("FAIL coll_nobypass: q=%h rvld=%b, want 11111111 1", q_b, rvld_b);
    end
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd7);
    tests++;
    if (rvld_a !== 1'b1 || q_a !== 32'h2211_1111) begin
      fails++;
      $display("FAIL coll_after_a: q=%h rvld=%b, want 22111111 1", q_a, rvld_a);
    end
    idle();
    tests++;
    if (rvld_b !== 1'b1 || q_b !== 32'h2211_1111) begin
      fails++;
      $display("FAIL coll_after_b: q=%h rvld=%b, want 22111111 1", q_b, rvld_b);
    end
    $display("[TB] collision addr 7 q_a=%h q_b=%h", q_a, q_b);
  endtask

  task automatic test_wen_zero();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    addr = AW'($urandom_range(100, 200));
    data = DW'($urandom);
    cycle(1'b1, addr, data, 32'hFFFF_FFFF, 1'b0, '0);
    cycle(1'b1, addr, ~data, 32'h0000_0000, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, addr);
    tests++;
    if (rvld_a !== 1'b1 || q_a !== data) begin
      fails++;
      $display("FAIL wen_zero_a: q=%h rvld=%b, want %h 1", q_a, rvld_a, data);
    end
    idle();
    tests++;
    if (rvld_b !== 1'b1 || q_b !== data) begin
      fails++;
      $display("FAIL wen_zero_b: q=%h rvld=%b, want %h 1", q_b, rvld_b, data);
    end
    $display("[TB] zero-mask write addr %0d data kept %h", addr, q_a);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), DW'(i), 32'hFFFF_FFFF, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, AW'(i));
      want = DW'(i);
      tests++;
      if (rvld_a !== 1'b1 || q_a !== want) begin
        fails++;
        $display("FAIL b2b_a[%0d]: q=%h rvld=%b, want %h 1", i, q_a, rvld_a, want);
      end
      if (i > 0) begin
        want = DW'(i - 1);
        tests++;
        if (rvld_b !== 1'b1 || q_b !== want) begin
          fails++;
          $display("FAIL b2b_b[%0d]: q=%h rvld=%b, want %h 1", i, q_b, rvld_b, want);
        end
      end
    end
    idle();
    tests++;
    if (rvld_a !== 1'b0 || q_a !== 32'd15 || rvld_b !== 1'b1 || q_b !== 32'd15) begin
      fails++;
      $display("FAIL b2b_tail1: q_a=%h rvld_a=%b q_b=%h rvld_b=%b, want f 0 f 1", q_a, rvld_a, q_b, rvld_b);
    end
    idle();
    tests++;
    if (rvld_a !== 1'b0 || q_a !== 32'd15 || rvld_b !== 1'b0 || q_b !== 32'd15) begin
      fails++;
      $display("FAIL b2b_tail2: q_a=%h rvld_a=%b q_b=%h rvld_b=%b, want f 0 f 0", q_a, rvld_a, q_b, rvld_b);
    end
    $display("[TB] back-to-back 16 reads done");
  endtask

  task automatic test_random();
    logic [DW-1:0] m;
    int            sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      m   = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : DW'($urandom);
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), m,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
      tests++;
      if (q_a !== exp_a_q || rvld_a !== exp_a_vld || busy_a !== exp_busy) begin
        fails++;
        $display("FAIL rand_a[%0d]: q=%h rvld=%b busy=%b, want %h %b %b",
                 n, q_a, rvld_a, busy_a, exp_a_q, exp_a_vld, exp_busy);
      end
      tests++;
      if (q_b !== exp_b_q || rvld_b !== exp_b_vld || busy_b !== exp_busy) begin
        fails++;
        $display("FAIL rand_b[%0d]: q=%h rvld=%b busy=%b, want %h %b %b",
                 n, q_b, rvld_b, busy_b, exp_b_q, exp_b_vld, exp_busy);
      end
    end
    $display("[TB] random traffic 400 cycles done");
  endtask

  task automatic test_reset_midstream();
    int na, nb, bad;
    logic [AW-1:0] addrs [4];
    addrs[0] = 10'd3; addrs[1] = 10'd9; addrs[2] = 10'd5; addrs[3] = 10'd7;
    cycle(1'b1, 10'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, '0);
    cycle(1'b1, 10'd9, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd3);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd9);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd5);
    apply_reset();
    tests++;
    if (q_a !== '0 || rvld_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL midrst_a: q=%h rvld=%b busy=%b, want 0 0 1", q_a, rvld_a, busy_a);
    end
    tests++;
    if (q_b !== '0 || rvld_b !== 1'b0 || busy_b !== 1'b1) begin
      fails++;
      $display("FAIL midrst_b: q=%h rvld=%b busy=%b, want 0 0 1", q_b, rvld_b, busy_b);
    end
    idle();
    tests++;
    if (rvld_a !== 1'b0 || rvld_b !== 1'b0 || q_b !== '0) begin
      fails++;
      $display("FAIL midrst_late: rvld_a=%b rvld_b=%b q_b=%h, want 0 0 0", rvld_a, rvld_b, q_b);
    end
    rst = 1'b0;
    run_init(na, nb, bad);
    tests++;
    if (na != DEPTH || nb != DEPTH || bad != 0) begin
      fails++;
      $display("FAIL midrst_init: busy_a=%0d busy_b=%0d rvld_cycles=%0d, want %0d %0d 0",
               na, nb, bad, DEPTH, DEPTH);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, addrs[i]);
      tests++;
      if (rvld_a !== 1'b1 || q_a !== '0) begin
        fails++;
        $display("FAIL midrst_zero_a[%0d]: q=%h rvld=%b, want 0 1", addrs[i], q_a, rvld_a);
      end
    end
    idle();
    tests++;
    if (rvld_b !== 1'b1 || q_b !== '0) begin
      fails++;
      $display("FAIL midrst_zero_b: q=%h rvld=%b, want 0 1", q_b, rvld_b);
    end
    $display("[TB] mid-stream reset, re-init busy a=%0d b=%0d", na, nb);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    we = 1'b0; wa = '0; wd = '0; wen = '0; re = 1'b0; ra = '0;
    model_reset();
    test_reset();
    test_init();
    test_masked_write();
    test_collision();
    test_wen_zero();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
